// File: rtl/lumi_phy_fifo_if.sv
// LUMI PHY stream handshake bundle: data with valid/ready.
// master drives data/vld, slave drives rdy.
interface lumi_phy_fifo_if #(
  parameter int IOW = 64
);
  logic [IOW-1:0] data;
  logic           vld;
  logic           rdy;

  modport master (
    output data,
    output vld,
    input  rdy
  );

  modport slave (
    input  data,
    input  vld,
    output rdy
  );
endinterface

// File: rtl/lumi_phy_fifo.sv
// LUMI PHY elastic FIFO, FWFT, fully registered outputs, ioclk domain.
// Optional stats counters: define LUMI_PHY_FIFO_STATS_EN.
module lumi_phy_fifo #(
  parameter int IOW   = 64,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH+1)
) (
  input  logic             ioclk,
  input  logic             ionreset,
  input  logic             csr_en,
  lumi_phy_fifo_if.slave   phy_in,
  lumi_phy_fifo_if.master  phy_out,
  output logic [CNTW-1:0]  fifo_count,
  output logic             fifo_overflow
`ifdef LUMI_PHY_FIFO_STATS_EN
  ,
  output logic [31:0]      fifo_push_cnt,
  output logic [31:0]      fifo_stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  logic [IOW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [IOW-1:0]  dout_q, dout_d;
  logic            in_rdy_q, in_rdy_d;
  logic            out_vld_q, out_vld_d;
  logic            ovf_q, ovf_d;
  logic            push, pop, head_new;

  assign push = phy_in.vld & in_rdy_q;
  assign pop  = out_vld_q & phy_out.rdy;

  // The word written this cycle becomes the head when
  // nothing older survives the pop.
  assign head_new = push & (count_q == CNTW'(pop));

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    dout_d    = dout_q;
    in_rdy_d  = 1'b0;
    out_vld_d = 1'b0;
    ovf_d     = 1'b0;
    if (csr_en) begin
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(pop);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
      if (count_d != '0) begin
        dout_d = head_new ? phy_in.data
                          : mem_q[rptr_d];
      end
      in_rdy_d  = (count_d < FULL);
      out_vld_d = (count_d != '0);
      ovf_d     = ovf_q
                | (phy_in.vld & ~in_rdy_q
                   & (count_q == FULL));
    end else begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge ioclk) begin
    if (csr_en && push) begin
      mem_q[wptr_q] <= phy_in.data;
    end
  end

  always_ff @(posedge ioclk or negedge ionreset) begin
    if (!ionreset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      dout_q    <= '0;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign phy_in.rdy    = in_rdy_q;
  assign phy_out.vld   = out_vld_q;
  assign phy_out.data  = dout_q;
  assign fifo_count    = count_q;
  assign fifo_overflow = ovf_q;

`ifdef LUMI_PHY_FIFO_STATS_EN
  logic [31:0] push_cnt_q, push_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    push_cnt_d  = '0;
    stall_cnt_d = '0;
    if (csr_en) begin
      push_cnt_d  = push_cnt_q + 32'(push);
      stall_cnt_d = stall_cnt_q
                  + 32'(phy_in.vld & ~in_rdy_q);
    end
  end

  always_ff @(posedge ioclk or negedge ionreset) begin
    if (!ionreset) begin
      push_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      push_cnt_q  <= push_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fifo_push_cnt  = push_cnt_q;
  assign fifo_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_lumi_phy_fifo.sv
// Randomized bench for lumi_phy_fifo against a queue-based model.
// Define LUMI_PHY_FIFO_STATS_EN to also check the stats counters.
module tb_lumi_phy_fifo;

  localparam int IOW   = 64;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH+1);

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [CNTW-1:0] cnt;
  logic            ovf;
`ifdef LUMI_PHY_FIFO_STATS_EN
  logic [31:0]     pcnt, scnt;
`endif

  lumi_phy_fifo_if #(.IOW(IOW)) pin ();
  lumi_phy_fifo_if #(.IOW(IOW)) pout ();

  lumi_phy_fifo #(
    .IOW(IOW), .DEPTH(DEPTH)
  ) dut (
    .ioclk         (clk),
    .ionreset      (rst_n),
    .csr_en        (en),
    .phy_in        (pin.slave),
    .phy_out       (pout.master),
    .fifo_count    (cnt),
    .fifo_overflow (ovf)
`ifdef LUMI_PHY_FIFO_STATS_EN
    ,
    .fifo_push_cnt (pcnt),
    .fifo_stall_cnt(scnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  // reference model state
  logic [IOW-1:0] q[$];
  bit             m_rdy, m_vld, m_ovf;
  logic [IOW-1:0] m_last;
  int unsigned    m_push, m_stall;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rdy   = 0;
    m_vld   = 0;
    m_ovf   = 0;
    m_last  = '0;
    m_push  = 0;
    m_stall = 0;
  endtask

  task automatic compare();
    chk("count", 64'(cnt), 64'(q.size()));
    chk("in_rdy", 64'(pin.rdy), 64'(m_rdy));
    chk("out_vld", 64'(pout.vld), 64'(m_vld));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("data", pout.data, m_last);
`ifdef LUMI_PHY_FIFO_STATS_EN
    chk("push_cnt", 64'(pcnt), 64'(m_push));
    chk("stall_cnt", 64'(scnt), 64'(m_stall));
`endif
  endtask

  // Drive at negedge, model at posedge, check at next negedge.
  task automatic step(input bit e, input bit v,
                      input logic [IOW-1:0] d,
                      input bit r, output bit pushed);
    bit psh, pp, full;
    en       = e;
    pin.vld  = v;
    pin.data = d;
    pout.rdy = r;
    @(posedge clk);
    psh  = v && m_rdy;
    pp   = r && m_vld;
    full = (q.size() == DEPTH);
    pushed = 0;
    if (!e) begin
      q.delete();
      m_ovf   = 0;
      m_push  = 0;
      m_stall = 0;
    end else begin
      if (v && !m_rdy && full) m_ovf = 1;
      if (v && !m_rdy) m_stall++;
      if (pp) void'(q.pop_front());
      if (psh) begin
        q.push_back(d);
        m_push++;
        pushed = 1;
      end
    end
    m_rdy = e && (q.size() < DEPTH);
    m_vld = e && (q.size() != 0);
    if (q.size() != 0) m_last = q[0];
    @(negedge clk);
    compare();
  endtask

  bit             ok;
  int             nxt;
  int             words;
  int             cyc;
  logic [IOW-1:0] rd;

  initial begin
    errs   = 0;
    checks = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    pin.vld  = 1'b0;
    pin.data = '0;
    pout.rdy = 1'b0;
    model_reset();
    #3;
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    // enable: in_rdy rises after the first edge
    step(1, 0, '0, 0, ok);

    // streaming 1..4 with out_rdy high
    for (int i = 1; i <= 4; i++)
      step(1, 1, IOW'(i), 1, ok);
    step(1, 0, '0, 1, ok);

    // 6 words offered into a stalled sink
    nxt = 1;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, IOW'(nxt), 0, ok);
      if (ok) nxt++;
    end
    // full with simultaneous push attempt and pop
    step(1, 1, IOW'(nxt), 1, ok);
    if (ok) nxt++;
    step(1, 0, '0, 0, ok);
    step(1, 1, IOW'(nxt), 0, ok);
    if (ok) nxt++;
    // drain the rest, finishing words up to 6
    for (int i = 0; i < 12; i++) begin
      step(1, nxt <= 6, IOW'(nxt), 1, ok);
      if (ok) nxt++;
    end

    // 3 buffered then a 1-cycle flush
    for (int i = 0; i < 3; i++)
      step(1, 1, IOW'(32'h100 + i), 0, ok);
    step(0, 0, '0, 0, ok);
    step(1, 0, '0, 0, ok);
    for (int i = 0; i < 3; i++)
      step(1, 1, IOW'(32'h200 + i), 0, ok);
    for (int i = 0; i < 4; i++)
      step(1, 0, '0, 1, ok);

    // 8 pushes and 5 stall cycles, then flush
    step(0, 0, '0, 0, ok);
    step(1, 0, '0, 0, ok);
    for (int i = 0; i < 4; i++)
      step(1, 1, IOW'(32'h300 + i), 0, ok);
    for (int i = 0; i < 5; i++)
      step(1, 1, IOW'(32'h3ff), 0, ok);
    for (int i = 0; i < 4; i++)
      step(1, 0, '0, 1, ok);
    for (int i = 0; i < 4; i++)
      step(1, 1, IOW'(32'h310 + i), 1, ok);
    step(0, 0, '0, 0, ok);

    // random traffic with occasional flushes
    words = 0;
    cyc   = 0;
    while (words < 10000 && cyc < 40000) begin
      rd = {$urandom, $urandom};
      step($urandom_range(0, 499) != 0,
           $urandom_range(0, 9) < 7, rd,
           $urandom_range(0, 9) < 6, ok);
      if (ok) words++;
      cyc++;
    end
    chk("random_words_done", 64'(words >= 10000), 64'(1));

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++)
      step(1, 1, {$urandom, $urandom}, 0, ok);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, IOW'(32'h55), 1, ok);
    step(1, 1, IOW'(32'h66), 1, ok);
    step(1, 0, '0, 1, ok);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
